mem_arbiter: RTL and testbench

Three-requester arbiter sharing the CPU's single-port 16-bit program/data RAM between instruction fetch, data access (MOV/LEA) and stack access (PUSH/POP/CALL/RET). Round-robin grant, one access per cycle, synchronous RAM with 1-cycle read latency, plus a bounded lock so CALL/RET multi-word stack sequences are atomic. Sits between the CPU core and the RAM macro.

---
 rtl/mem_arbiter_pkg.sv | 35 +++
 rtl/mem_arbiter_if.sv | 32 +++
 rtl/mem_arbiter_rr_pick.sv | 33 +++
 rtl/mem_arbiter.sv | 134 +++++++++++++
 tb/tb_mem_arbiter.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared constants and helpers for the three-requester RAM arbiter.
package mem_arb_pkg;

   localparam int NREQ   = 3;
   localparam int DEF_AW = 11;
   localparam int DEF_DW = 16;

   localparam logic [1:0] REQ_FETCH = 2'd0;
   localparam logic [1:0] REQ_DATA  = 2'd1;
   localparam logic [1:0] REQ_STACK = 2'd2;

   // Next requester index in round-robin order, wrapping stack back to fetch.
   function automatic logic [1:0] rr_next(input logic [1:0] i);
      logic [1:0] n;
      case (i)
         REQ_FETCH: n = REQ_DATA;
         REQ_DATA:  n = REQ_STACK;
         default:   n = REQ_FETCH;
      endcase
      return n;
   endfunction

   // Requester index to one-hot grant vector; out-of-range index gives no grant.
   function automatic logic [NREQ-1:0] idx_to_onehot(input logic [1:0] i);
      logic [NREQ-1:0] oh;
      case (i)
         REQ_FETCH: oh = 3'b001;
         REQ_DATA:  oh = 3'b010;
         REQ_STACK: oh = 3'b100;
         default:   oh = 3'b000;
      endcase
      return oh;
   endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Requester-side and RAM-side signals of the arbiter. The arbiter uses the
// slave view; the CPU core and RAM macro together form the master view.
interface mem_arbiter_if
   import mem_arb_pkg::*;
#(
   parameter int AW = DEF_AW,
   parameter int DW = DEF_DW
);
   logic [NREQ-1:0]    req;
   logic [NREQ-1:0]    we;
   logic [NREQ-1:0]    lock;
   logic [NREQ*AW-1:0] addr;
   logic [NREQ*DW-1:0] wdata;
   logic [NREQ-1:0]    gnt;
   logic [NREQ-1:0]    rvalid;
   logic [DW-1:0]      rdata;
   logic               mem_en;
   logic               mem_we;
   logic [AW-1:0]      mem_addr;
   logic [DW-1:0]      mem_wdata;
   logic [DW-1:0]      mem_rdata;

   modport slave (
      input  req, we, lock, addr, wdata, mem_rdata,
      output gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output req, we, lock, addr, wdata, mem_rdata,
      input  gnt, rvalid, rdata, mem_en, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter_rr_pick.sv
// Combinational 3-way round-robin picker: scans rr_ptr+1, rr_ptr+2, rr_ptr.
module rr_pick
   import mem_arb_pkg::*;
(
   input  logic [NREQ-1:0] req,
   input  logic [1:0]      rr_ptr,
   output logic [NREQ-1:0] gnt,
   output logic [1:0]      idx,
   output logic            found
);
   logic [1:0] cand_s;

   // First requesting index after the last granted one wins.
   always_comb begin
      found  = 1'b0;
      idx    = 2'd0;
      cand_s = rr_ptr;
      for (int k = 0; k < NREQ; k++) begin
         cand_s = rr_next(cand_s);
         if (!found && req[cand_s]) begin
            found = 1'b1;
            idx   = cand_s;
         end else begin
            found = found;
         end
      end
      if (found) begin
         gnt = idx_to_onehot(idx);
      end else begin
         gnt = 3'b000;
      end
   end
endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing the single-port program/data RAM between
// fetch, data and stack requesters, with a bounded lock for atomic
// multi-word stack sequences. Grant is combinational; read data returns
// one cycle after the grant.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW       = DEF_AW,
   parameter int DW       = DEF_DW,
   parameter int LOCK_MAX = 4
)(
   input  logic          clk,
   input  logic          reset,
   mem_arbiter_if.slave  bus
);
   localparam int CW = $clog2(LOCK_MAX + 1);
   localparam logic [CW-1:0] LOCK_MAX_C = CW'(LOCK_MAX);

   logic [NREQ-1:0] req_eff_s;
   logic [NREQ-1:0] pick_gnt_s;
   logic [1:0]      pick_idx_s;
   logic            pick_vld_s;
   logic [NREQ-1:0] gnt_s;
   logic [1:0]      win_idx_s;
   logic            win_vld_s;

   logic [1:0]      rr_ptr_r;
   logic [NREQ-1:0] rv_q_r;
   logic            lock_act_r;
   logic [1:0]      lock_own_r;
   logic [CW-1:0]   lock_cnt_r;
   logic            lock_act_nx_s;
   logic [1:0]      lock_own_nx_s;
   logic [CW-1:0]   lock_cnt_nx_s;
   logic [CW-1:0]   cnt_inc_s;

   // Requests are masked while reset is held so every output reads zero.
   assign req_eff_s = reset ? 3'b000 : bus.req;

   rr_pick u_pick (
      .req    (req_eff_s),
      .rr_ptr (rr_ptr_r),
      .gnt    (pick_gnt_s),
      .idx    (pick_idx_s),
      .found  (pick_vld_s)
   );

   // Winner: an active lock owner that is still requesting overrides round-robin.
   always_comb begin
      win_idx_s = pick_idx_s;
      win_vld_s = pick_vld_s;
      gnt_s     = pick_gnt_s;
      if (lock_act_r && (lock_own_r <= REQ_STACK) && req_eff_s[lock_own_r]) begin
         win_idx_s = lock_own_r;
         win_vld_s = 1'b1;
         gnt_s     = idx_to_onehot(lock_own_r);
      end else begin
         win_vld_s = pick_vld_s;
      end
   end

   // RAM port is driven from the winner; all zero when nobody is granted.
   always_comb begin
      bus.mem_en    = 1'b0;
      bus.mem_we    = 1'b0;
      bus.mem_addr  = {AW{1'b0}};
      bus.mem_wdata = {DW{1'b0}};
      if (win_vld_s) begin
         bus.mem_en    = 1'b1;
         bus.mem_we    = bus.we[win_idx_s];
         bus.mem_addr  = bus.addr[win_idx_s*AW +: AW];
         bus.mem_wdata = bus.wdata[win_idx_s*DW +: DW];
      end else begin
         bus.mem_en    = 1'b0;
      end
   end

   // Lock bookkeeping: only the granted requester's lock bit matters; the lock
   // ends on a grant without lock or when the count reaches LOCK_MAX.
   always_comb begin
      lock_act_nx_s = lock_act_r;
      lock_own_nx_s = lock_own_r;
      lock_cnt_nx_s = lock_cnt_r;
      cnt_inc_s     = CW'(1);
      if (win_vld_s) begin
         if (bus.lock[win_idx_s]) begin
            if (lock_act_r && (lock_own_r == win_idx_s)) begin
               cnt_inc_s = lock_cnt_r + CW'(1);
            end else begin
               cnt_inc_s = CW'(1);
            end
            lock_own_nx_s = win_idx_s;
            if (cnt_inc_s >= LOCK_MAX_C) begin
               lock_act_nx_s = 1'b0;
               lock_cnt_nx_s = {CW{1'b0}};
            end else begin
               lock_act_nx_s = 1'b1;
               lock_cnt_nx_s = cnt_inc_s;
            end
         end else begin
            lock_act_nx_s = 1'b0;
            lock_cnt_nx_s = {CW{1'b0}};
         end
      end else begin
         lock_act_nx_s = lock_act_r;
      end
   end

   // Arbitration state; reset drops any pending read valid and the lock.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rr_ptr_r   <= REQ_STACK;
         rv_q_r     <= 3'b000;
         lock_act_r <= 1'b0;
         lock_own_r <= 2'd0;
         lock_cnt_r <= {CW{1'b0}};
      end else begin
         lock_act_r <= lock_act_nx_s;
         lock_own_r <= lock_own_nx_s;
         lock_cnt_r <= lock_cnt_nx_s;
         if (win_vld_s) begin
            rr_ptr_r <= win_idx_s;
            rv_q_r   <= bus.we[win_idx_s] ? 3'b000 : gnt_s;
         end else begin
            rv_q_r   <= 3'b000;
         end
      end
   end

   assign bus.gnt    = gnt_s;
   assign bus.rvalid = rv_q_r;
   assign bus.rdata  = (|rv_q_r) ? bus.mem_rdata : {DW{1'b0}};

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: vector table plus hand sequences,
// read data checked through a scoreboard against a shadow copy of RAM.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   localparam int AW = 11;
   localparam int DW = 16;
   localparam int LM = 4;

   typedef struct {
      logic [2:0]         req;
      logic [2:0]         we;
      logic [2:0]         lock;
      logic [2:0][AW-1:0] a;
      logic [2:0][DW-1:0] d;
      logic [2:0]         eg;
   } vec_t;

   typedef struct {
      int          due;
      logic [2:0]  rv;
      logic [DW-1:0] data;
   } sb_t;

   logic clk;
   logic reset;
   logic pre_en;
   logic [AW-1:0] pre_a;
   logic [DW-1:0] pre_d;
   logic [DW-1:0] ram [0:(1<<AW)-1];
   logic [DW-1:0] shadow [0:(1<<AW)-1];
   logic [DW-1:0] ram_q;

   int checks;
   int failures;
   int cyc;
   sb_t sbq[$];
   vec_t tbl[$];

   mem_arbiter_if #(.AW(AW), .DW(DW)) bus ();

   mem_arbiter #(.AW(AW), .DW(DW), .LOCK_MAX(LM)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural synchronous RAM with a bench preload port.
   always @(posedge clk) begin
      if (pre_en) begin
         ram[pre_a] <= pre_d;
      end else if (bus.mem_en) begin
         if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
         else            ram_q <= ram[bus.mem_addr];
      end
   end
   assign bus.mem_rdata = ram_q;

   function automatic logic [DW-1:0] init_val(input int i);
      if (i == 5) return 16'h1234;
      return 16'(i) ^ 16'h5A00;
   endfunction

   function automatic vec_t mkv(input logic [2:0] req, input logic [2:0] we,
                                input logic [2:0] lock, input logic [AW-1:0] a0,
                                input logic [AW-1:0] a1, input logic [AW-1:0] a2,
                                input logic [DW-1:0] d0, input logic [DW-1:0] d1,
                                input logic [DW-1:0] d2, input logic [2:0] eg);
      vec_t v;
      v.req = req; v.we = we; v.lock = lock;
      v.a[0] = a0; v.a[1] = a1; v.a[2] = a2;
      v.d[0] = d0; v.d[1] = d1; v.d[2] = d2;
      v.eg = eg;
      return v;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s cyc=%0d actual=%h required=%h", nm, cyc, act, exp);
      end
   endtask

   // rvalid/rdata for the current cycle come from the scoreboard front entry.
   task automatic sb_check();
      sb_t e;
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
         e = sbq.pop_front();
         chk("rvalid", 32'(bus.rvalid), 32'(e.rv));
         chk("rdata", 32'(bus.rdata), 32'(e.data));
      end else begin
         chk("rvalid_idle", 32'(bus.rvalid), 32'd0);
         chk("rdata_idle", 32'(bus.rdata), 32'd0);
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_gnt"}, 32'(bus.gnt), 32'd0);
      chk({nm, "_rvalid"}, 32'(bus.rvalid), 32'd0);
      chk({nm, "_rdata"}, 32'(bus.rdata), 32'd0);
      chk({nm, "_mem_en"}, 32'(bus.mem_en), 32'd0);
      chk({nm, "_mem_we"}, 32'(bus.mem_we), 32'd0);
      chk({nm, "_mem_addr"}, 32'(bus.mem_addr), 32'd0);
      chk({nm, "_mem_wdata"}, 32'(bus.mem_wdata), 32'd0);
   endtask

   // Drive one cycle of requests, check outputs mid-cycle, update models, step.
   task automatic apply(input vec_t v);
      int idx;
      sb_t e;
      bus.req = v.req; bus.we = v.we; bus.lock = v.lock;
      bus.addr = v.a; bus.wdata = v.d;
      @(negedge clk);
      chk("gnt", 32'(bus.gnt), 32'(v.eg));
      idx = (v.eg == 3'b010) ? 1 : (v.eg == 3'b100) ? 2 : 0;
      if (v.eg != 3'b000) begin
         chk("mem_en", 32'(bus.mem_en), 32'd1);
         chk("mem_we", 32'(bus.mem_we), 32'(v.we[idx]));
         chk("mem_addr", 32'(bus.mem_addr), 32'(v.a[idx]));
         chk("mem_wdata", 32'(bus.mem_wdata), 32'(v.d[idx]));
      end else begin
         chk("mem_en_idle", 32'(bus.mem_en), 32'd0);
         chk("mem_addr_idle", 32'(bus.mem_addr), 32'd0);
      end
      sb_check();
      if (v.eg != 3'b000) begin
         if (v.we[idx]) begin
            shadow[v.a[idx]] = v.d[idx];
         end else begin
            e.due = cyc + 1; e.rv = v.eg; e.data = shadow[v.a[idx]];
            sbq.push_back(e);
         end
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   initial begin
      checks = 0; failures = 0; cyc = 0;
      reset = 1'b1; pre_en = 1'b0; pre_a = '0; pre_d = '0; ram_q = '0;
      bus.req = 3'b000; bus.we = 3'b000; bus.lock = 3'b000;
      bus.addr = '0; bus.wdata = '0;

      // Preload the first 512 RAM words and mirror them in the shadow copy.
      #1;
      for (int i = 0; i < 512; i++) begin
         pre_en = 1'b1; pre_a = AW'(i); pre_d = init_val(i);
         shadow[i] = init_val(i);
         @(posedge clk); #1;
      end
      pre_en = 1'b0;

      // Outputs stay zero in reset even with every requester asking.
      bus.req = 3'b111;
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk); #1;
      reset = 1'b0;
      bus.req = 3'b000;

      //            req     we      lock    a0      a1      a2      d0       d1       d2       gnt
      tbl.push_back(mkv(3'b111, 3'b000, 3'b000, 11'h010, 11'h020, 11'h030, 16'h0, 16'h0, 16'h0, 3'b001));
      tbl.push_back(mkv(3'b111, 3'b000, 3'b000, 11'h010, 11'h020, 11'h030, 16'h0, 16'h0, 16'h0, 3'b010));
      tbl.push_back(mkv(3'b111, 3'b000, 3'b000, 11'h010, 11'h020, 11'h030, 16'h0, 16'h0, 16'h0, 3'b100));
      tbl.push_back(mkv(3'b111, 3'b000, 3'b000, 11'h010, 11'h020, 11'h030, 16'h0, 16'h0, 16'h0, 3'b001));
      tbl.push_back(mkv(3'b001, 3'b000, 3'b000, 11'h005, 11'h000, 11'h000, 16'h0, 16'h0, 16'h0, 3'b001));
      tbl.push_back(mkv(3'b000, 3'b000, 3'b000, 11'h000, 11'h000, 11'h000, 16'h0, 16'h0, 16'h0, 3'b000));
      tbl.push_back(mkv(3'b010, 3'b010, 3'b000, 11'h000, 11'h00A, 11'h000, 16'h0, 16'hBEEF, 16'h0, 3'b010));
      tbl.push_back(mkv(3'b001, 3'b000, 3'b000, 11'h00A, 11'h000, 11'h000, 16'h0, 16'h0, 16'h0, 3'b001));
      tbl.push_back(mkv(3'b000, 3'b000, 3'b000, 11'h000, 11'h000, 11'h000, 16'h0, 16'h0, 16'h0, 3'b000));
      tbl.push_back(mkv(3'b110, 3'b100, 3'b000, 11'h000, 11'h040, 11'h040, 16'h0, 16'h0, 16'h5555, 3'b010));
      tbl.push_back(mkv(3'b110, 3'b100, 3'b000, 11'h000, 11'h040, 11'h040, 16'h0, 16'h0, 16'h5555, 3'b100));
      tbl.push_back(mkv(3'b010, 3'b000, 3'b000, 11'h000, 11'h040, 11'h000, 16'h0, 16'h0, 16'h0, 3'b010));
      tbl.push_back(mkv(3'b000, 3'b000, 3'b000, 11'h000, 11'h000, 11'h000, 16'h0, 16'h0, 16'h0, 3'b000));
      tbl.push_back(mkv(3'b110, 3'b000, 3'b010, 11'h000, 11'h050, 11'h060, 16'h0, 16'h0, 16'h0, 3'b100));
      tbl.push_back(mkv(3'b111, 3'b000, 3'b000, 11'h050, 11'h050, 11'h060, 16'h0, 16'h0, 16'h0, 3'b001));
      tbl.push_back(mkv(3'b000, 3'b000, 3'b000, 11'h000, 11'h000, 11'h000, 16'h0, 16'h0, 16'h0, 3'b000));
      foreach (tbl[i]) apply(tbl[i]);

      // Locked two-word stack write holds off fetch and data, then readback.
      apply(mkv(3'b010, 3'b000, 3'b000, 11'h000, 11'h070, 11'h000, 16'h0, 16'h0, 16'h0, 3'b010));
      apply(mkv(3'b111, 3'b100, 3'b100, 11'h100, 11'h101, 11'h100, 16'h0, 16'h0, 16'h0007, 3'b100));
      apply(mkv(3'b111, 3'b100, 3'b000, 11'h100, 11'h101, 11'h101, 16'h0, 16'h0, 16'h0012, 3'b100));
      apply(mkv(3'b011, 3'b000, 3'b000, 11'h100, 11'h101, 11'h000, 16'h0, 16'h0, 16'h0, 3'b001));
      apply(mkv(3'b010, 3'b000, 3'b000, 11'h000, 11'h101, 11'h000, 16'h0, 16'h0, 16'h0, 3'b010));
      apply(mkv(3'b000, 3'b000, 3'b000, 11'h000, 11'h000, 11'h000, 16'h0, 16'h0, 16'h0, 3'b000));

      // Lock held continuously: exactly LOCK_MAX stack grants, then fetch.
      for (int i = 0; i < LM; i++)
         apply(mkv(3'b111, 3'b000, 3'b100, 11'h010, 11'h020, 11'h030, 16'h0, 16'h0, 16'h0, 3'b100));
      apply(mkv(3'b111, 3'b000, 3'b100, 11'h010, 11'h020, 11'h030, 16'h0, 16'h0, 16'h0, 3'b001));
      apply(mkv(3'b000, 3'b000, 3'b000, 11'h000, 11'h000, 11'h000, 16'h0, 16'h0, 16'h0, 3'b000));

      // Data read granted, reset asserted in the following cycle before rvalid edge.
      bus.req = 3'b010; bus.we = 3'b000; bus.lock = 3'b000;
      bus.addr = {11'h000, 11'h077, 11'h000};
      @(negedge clk);
      chk("rst_seq_gnt", 32'(bus.gnt), 32'b010);
      @(posedge clk); cyc++; #1;
      reset = 1'b1;
      #1;
      chk_all_zero("rst_mid");
      @(negedge clk);
      chk_all_zero("rst_hold");
      @(posedge clk); cyc++; #1;
      bus.req = 3'b000;
      reset = 1'b0;
      sbq.delete();
      @(negedge clk);
      chk("rst_after_rvalid", 32'(bus.rvalid), 32'd0);
      @(posedge clk); cyc++; #1;
      // Pointer back at its reset value: fetch wins a full request.
      apply(mkv(3'b111, 3'b000, 3'b000, 11'h010, 11'h020, 11'h030, 16'h0, 16'h0, 16'h0, 3'b001));
      apply(mkv(3'b000, 3'b000, 3'b000, 11'h000, 11'h000, 11'h000, 16'h0, 16'h0, 16'h0, 3'b000));

      if (sbq.size() != 0) begin
         failures++;
         $display("FAIL sb_drain actual=%0d required=0", sbq.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
